// File: rtl/pkt_engine_dispatch.sv
// Packet-atomic round-robin dispatcher: commits one ready engine, then steers a
// complete sop..eop packet to it with a single registered cycle of latency.
module pkt_engine_dispatch #(
    parameter int NUM_ENG = 4,
    parameter int DW      = 32,
    parameter int CW      = 16
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic                       in_sop,
    input  logic                       in_eop,
    input  logic                       in_vld,
    input  logic [DW-1:0]              in_data,
    output logic                       in_enable,
    input  logic [NUM_ENG-1:0]         eng_enable,
    output logic [NUM_ENG-1:0]         eng_sop,
    output logic [NUM_ENG-1:0]         eng_eop,
    output logic [NUM_ENG-1:0]         eng_vld,
    output logic [DW-1:0]              eng_data,
    output logic [$clog2(NUM_ENG)-1:0] grant_idx,
    output logic [CW-1:0]              pkt_cnt,
    output logic                       err_pulse
);

    localparam int GW = $clog2(NUM_ENG);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        XFER  = 2'd2
    } state_e;

    state_e             state_q;
    logic [GW-1:0]      rr_ptr_q;
    logic [GW-1:0]      grant_idx_q;
    logic [NUM_ENG-1:0] eng_sop_q;
    logic [NUM_ENG-1:0] eng_eop_q;
    logic [NUM_ENG-1:0] eng_vld_q;
    logic [DW-1:0]      eng_data_q;
    logic [CW-1:0]      pkt_cnt_q;
    logic               err_q;

    logic               fwd_d;
    logic               last_d;
    logic               err_d;
    logic [GW-1:0]      arb_idx_d;
    logic               arb_found_d;
    logic [GW-1:0]      cand_idx;
    logic [GW-1:0]      rr_next_d;

    // Descending scan so the candidate nearest rr_ptr is the last one written.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        arb_idx_d   = rr_ptr_q;
        arb_found_d = 1'b0;
        cand_idx    = '0;
        for (int i = NUM_ENG - 1; i >= 0; i--) begin
            cand_idx = GW'((int'(rr_ptr_q) + i) % NUM_ENG);
            if (eng_enable[cand_idx]) begin
                arb_idx_d   = cand_idx;
                arb_found_d = 1'b1;
            end
        end
    end

    always_comb begin
        fwd_d = 1'b0;
        err_d = 1'b0;
        unique case (state_q)
            IDLE:  err_d = in_vld;
            ARMED: begin
                if (in_vld && in_sop) fwd_d = 1'b1;
                else if (in_vld)      err_d = 1'b1;
            end
            XFER: begin
                if (in_vld && in_sop) err_d = 1'b1;
                else if (in_vld)      fwd_d = 1'b1;
            end
            default: ;
        endcase
        last_d    = fwd_d & in_eop;
        rr_next_d = (grant_idx_q == GW'(NUM_ENG - 1)) ? '0 : grant_idx_q + 1'b1;
    end

    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (sys_rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            eng_sop_q   <= '0;
            eng_eop_q   <= '0;
            eng_vld_q   <= '0;
            eng_data_q  <= '0;
            pkt_cnt_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            eng_sop_q <= '0;
            eng_eop_q <= '0;
            eng_vld_q <= '0;
            err_q     <= err_d;

            if (fwd_d) begin
                eng_vld_q[grant_idx_q] <= 1'b1;
                eng_sop_q[grant_idx_q] <= in_sop;
                eng_eop_q[grant_idx_q] <= in_eop;
                eng_data_q             <= in_data;
            end

            if (last_d) begin
                rr_ptr_q  <= rr_next_d;
                pkt_cnt_q <= pkt_cnt_q + 1'b1;
            end

            unique case (state_q)
                IDLE: begin
                    if (arb_found_d) begin
                        grant_idx_q <= arb_idx_d;
                        state_q     <= ARMED;
                    end
                end
                ARMED: begin
                    // A sop in this cycle takes precedence over the engine withdrawing.
                    if (fwd_d)                          state_q <= last_d ? IDLE : XFER;
                    else if (!eng_enable[grant_idx_q])  state_q <= IDLE;
                end
                XFER: begin
                    if (last_d) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_enable = (state_q == ARMED) || (state_q == XFER);
    assign eng_sop   = eng_sop_q;
    assign eng_eop   = eng_eop_q;
    assign eng_vld   = eng_vld_q;
    assign eng_data  = eng_data_q;
    assign grant_idx = grant_idx_q;
    assign pkt_cnt   = pkt_cnt_q;
    assign err_pulse = err_q;

endmodule

// File: tb/tb_pkt_engine_dispatch.sv
// Directed bench for pkt_engine_dispatch: arbitration order, multi-beat forwarding,
// engine withdrawal, protocol errors, mid-packet reset and packet-counter wrap.
module tb_pkt_engine_dispatch;

    localparam int NUM_ENG = 4;
    localparam int DW      = 32;
    // Narrow counter keeps the wrap scenario short.
    localparam int CW      = 8;

    logic               sys_clk;
    logic               sys_rst;
    logic               in_sop;
    logic               in_eop;
    logic               in_vld;
    logic [DW-1:0]      in_data;
    logic               in_enable;
    logic [NUM_ENG-1:0] eng_enable;
    logic [NUM_ENG-1:0] eng_sop;
    logic [NUM_ENG-1:0] eng_eop;
    logic [NUM_ENG-1:0] eng_vld;
    logic [DW-1:0]      eng_data;
    logic [1:0]         grant_idx;
    logic [CW-1:0]      pkt_cnt;
    logic               err_pulse;

    int tests_run    = 0;
    int tests_failed = 0;

    pkt_engine_dispatch #(.NUM_ENG(NUM_ENG), .DW(DW), .CW(CW)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .in_sop     (in_sop),
        .in_eop     (in_eop),
        .in_vld     (in_vld),
        .in_data    (in_data),
        .in_enable  (in_enable),
        .eng_enable (eng_enable),
        .eng_sop    (eng_sop),
        .eng_eop    (eng_eop),
        .eng_vld    (eng_vld),
        .eng_data   (eng_data),
        .grant_idx  (grant_idx),
        .pkt_cnt    (pkt_cnt),
        .err_pulse  (err_pulse)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic clear_beat();
        in_vld  = 1'b0;
        in_sop  = 1'b0;
        in_eop  = 1'b0;
        in_data = '0;
    endtask

    task automatic drive_beat(input logic sop, input logic eop, input logic [DW-1:0] data);
        in_vld  = 1'b1;
        in_sop  = sop;
        in_eop  = eop;
        in_data = data;
    endtask

    task automatic test_reset();
        sys_rst    = 1'b1;
        eng_enable = '0;
        clear_beat();
        tick();
        tick();
        sys_rst = 1'b0;
        tests_run++; if (in_enable !== 1'b0) begin tests_failed++; $display("FAIL reset_in_enable got=%0h exp=0", in_enable); end
        tests_run++; if (eng_vld !== 4'h0)   begin tests_failed++; $display("FAIL reset_eng_vld got=%0h exp=0", eng_vld); end
        tests_run++; if (eng_sop !== 4'h0 || eng_eop !== 4'h0) begin tests_failed++; $display("FAIL reset_sop_eop got=%0h/%0h exp=0/0", eng_sop, eng_eop); end
        tests_run++; if (eng_data !== 32'h0) begin tests_failed++; $display("FAIL reset_eng_data got=%0h exp=0", eng_data); end
        tests_run++; if (grant_idx !== 2'd0) begin tests_failed++; $display("FAIL reset_grant got=%0d exp=0", grant_idx); end
        tests_run++; if (pkt_cnt !== 8'd0)   begin tests_failed++; $display("FAIL reset_pkt_cnt got=%0d exp=0", pkt_cnt); end
        tests_run++; if (err_pulse !== 1'b0) begin tests_failed++; $display("FAIL reset_err got=%0h exp=0", err_pulse); end
    endtask

    // T1: all engines ready, four single-beat packets rotate grants 0..3.
    task automatic test_round_robin();
        logic [3:0] exp_oh;
        eng_enable = 4'hF;
        for (int k = 0; k < 4; k++) begin
            tick();
            tests_run++; if (in_enable !== 1'b1)  begin tests_failed++; $display("FAIL rr_armed[%0d] in_enable got=%0h exp=1", k, in_enable); end
            tests_run++; if (grant_idx !== 2'(k)) begin tests_failed++; $display("FAIL rr_grant[%0d] got=%0d exp=%0d", k, grant_idx, k); end
            drive_beat(1'b1, 1'b1, 32'(100 + k));
            tick();
            clear_beat();
            exp_oh = 4'b0001 << k;
            tests_run++; if (eng_vld !== exp_oh || eng_sop !== exp_oh || eng_eop !== exp_oh) begin
                tests_failed++; $display("FAIL rr_fwd[%0d] vld/sop/eop got=%0h/%0h/%0h exp=%0h", k, eng_vld, eng_sop, eng_eop, exp_oh); end
            tests_run++; if (eng_data !== 32'(100 + k)) begin tests_failed++; $display("FAIL rr_data[%0d] got=%0h exp=%0h", k, eng_data, 100 + k); end
            tests_run++; if (in_enable !== 1'b0) begin tests_failed++; $display("FAIL rr_after_eop[%0d] in_enable got=%0h exp=0", k, in_enable); end
        end
        tests_run++; if (pkt_cnt !== 8'd4) begin tests_failed++; $display("FAIL rr_pkt_cnt got=%0d exp=4", pkt_cnt); end
    endtask

    // T2: four-beat packet to engine 2 only, one-cycle latency per beat.
    task automatic test_multibeat();
        logic [3:0] exp_sop;
        logic [3:0] exp_eop;
        eng_enable = 4'b0100;
        tick();
        tests_run++; if (grant_idx !== 2'd2 || in_enable !== 1'b1) begin
            tests_failed++; $display("FAIL mb_grant got=%0d/%0h exp=2/1", grant_idx, in_enable); end
        for (int j = 0; j < 4; j++) begin
            drive_beat(j == 0, j == 3, 32'hA0 + 32'(j));
            tick();
            exp_sop = (j == 0) ? 4'b0100 : 4'b0000;
            exp_eop = (j == 3) ? 4'b0100 : 4'b0000;
            tests_run++; if (eng_vld !== 4'b0100) begin tests_failed++; $display("FAIL mb_vld[%0d] got=%0h exp=4", j, eng_vld); end
            tests_run++; if (eng_sop !== exp_sop || eng_eop !== exp_eop) begin
                tests_failed++; $display("FAIL mb_flags[%0d] sop/eop got=%0h/%0h exp=%0h/%0h", j, eng_sop, eng_eop, exp_sop, exp_eop); end
            tests_run++; if (eng_data !== 32'hA0 + 32'(j)) begin tests_failed++; $display("FAIL mb_data[%0d] got=%0h exp=%0h", j, eng_data, 32'hA0 + j); end
        end
        clear_beat();
        tick();
        tests_run++; if (eng_vld !== 4'h0 || eng_data !== 32'hA3) begin
            tests_failed++; $display("FAIL mb_hold vld/data got=%0h/%0h exp=0/a3", eng_vld, eng_data); end
        tests_run++; if (pkt_cnt !== 8'd5) begin tests_failed++; $display("FAIL mb_pkt_cnt got=%0d exp=5", pkt_cnt); end
    endtask

    // T3: no engine ready keeps upstream closed; engine 1 ready then gets the grant.
    task automatic test_no_engine();
        eng_enable = 4'b0000;
        tick();
        for (int c = 0; c < 10; c++) begin
            tick();
            tests_run++; if (in_enable !== 1'b0) begin tests_failed++; $display("FAIL idle_wait[%0d] in_enable got=%0h exp=0", c, in_enable); end
        end
        eng_enable = 4'b0010;
        tick();
        tests_run++; if (in_enable !== 1'b1 || grant_idx !== 2'd1) begin
            tests_failed++; $display("FAIL idle_grant in_enable/grant got=%0h/%0d exp=1/1", in_enable, grant_idx); end
    endtask

    // T4: engine withdraws while armed; then withdraws in the same cycle as a sop.
    task automatic test_withdraw();
        eng_enable = 4'b0000;
        tick();
        tests_run++; if (in_enable !== 1'b0) begin tests_failed++; $display("FAIL wd_drop in_enable got=%0h exp=0", in_enable); end
        eng_enable = 4'b0010;
        tick();
        tests_run++; if (in_enable !== 1'b1 || grant_idx !== 2'd1) begin
            tests_failed++; $display("FAIL wd_rearm in_enable/grant got=%0h/%0d exp=1/1", in_enable, grant_idx); end
        eng_enable = 4'b0000;
        drive_beat(1'b1, 1'b0, 32'h55);
        tick();
        tests_run++; if (eng_vld !== 4'b0010 || eng_sop !== 4'b0010 || eng_data !== 32'h55) begin
            tests_failed++; $display("FAIL wd_sop_wins vld/sop/data got=%0h/%0h/%0h exp=2/2/55", eng_vld, eng_sop, eng_data); end
        tests_run++; if (in_enable !== 1'b1) begin tests_failed++; $display("FAIL wd_xfer in_enable got=%0h exp=1", in_enable); end
        drive_beat(1'b0, 1'b1, 32'h56);
        tick();
        clear_beat();
        tests_run++; if (eng_vld !== 4'b0010 || eng_eop !== 4'b0010 || eng_data !== 32'h56) begin
            tests_failed++; $display("FAIL wd_eop vld/eop/data got=%0h/%0h/%0h exp=2/2/56", eng_vld, eng_eop, eng_data); end
        tests_run++; if (in_enable !== 1'b0 || pkt_cnt !== 8'd6) begin
            tests_failed++; $display("FAIL wd_done in_enable/pkt_cnt got=%0h/%0d exp=0/6", in_enable, pkt_cnt); end
    endtask

    // T5: protocol violations in IDLE, ARMED and XFER are dropped and flagged.
    task automatic test_errors();
        drive_beat(1'b0, 1'b0, 32'hE0);
        tick();
        clear_beat();
        tests_run++; if (err_pulse !== 1'b1 || eng_vld !== 4'h0) begin
            tests_failed++; $display("FAIL err_idle err/vld got=%0h/%0h exp=1/0", err_pulse, eng_vld); end
        tick();
        tests_run++; if (err_pulse !== 1'b0) begin tests_failed++; $display("FAIL err_idle_clear got=%0h exp=0", err_pulse); end
        eng_enable = 4'b1000;
        tick();
        tests_run++; if (grant_idx !== 2'd3) begin tests_failed++; $display("FAIL err_grant got=%0d exp=3", grant_idx); end
        drive_beat(1'b0, 1'b0, 32'hDEAD);
        tick();
        tests_run++; if (err_pulse !== 1'b1 || eng_vld !== 4'h0 || in_enable !== 1'b1) begin
            tests_failed++; $display("FAIL err_armed err/vld/in_enable got=%0h/%0h/%0h exp=1/0/1", err_pulse, eng_vld, in_enable); end
        drive_beat(1'b1, 1'b0, 32'h11);
        tick();
        tests_run++; if (err_pulse !== 1'b0 || eng_vld !== 4'b1000 || eng_sop !== 4'b1000) begin
            tests_failed++; $display("FAIL err_sop err/vld/sop got=%0h/%0h/%0h exp=0/8/8", err_pulse, eng_vld, eng_sop); end
        drive_beat(1'b1, 1'b0, 32'hBAD);
        tick();
        tests_run++; if (err_pulse !== 1'b1 || eng_vld !== 4'h0 || eng_data !== 32'h11) begin
            tests_failed++; $display("FAIL err_xfer err/vld/data got=%0h/%0h/%0h exp=1/0/11", err_pulse, eng_vld, eng_data); end
        drive_beat(1'b0, 1'b1, 32'h12);
        tick();
        clear_beat();
        tests_run++; if (err_pulse !== 1'b0 || eng_vld !== 4'b1000 || eng_eop !== 4'b1000 || eng_data !== 32'h12) begin
            tests_failed++; $display("FAIL err_eop err/vld/eop/data got=%0h/%0h/%0h/%0h exp=0/8/8/12", err_pulse, eng_vld, eng_eop, eng_data); end
        tests_run++; if (pkt_cnt !== 8'd7) begin tests_failed++; $display("FAIL err_pkt_cnt got=%0d exp=7", pkt_cnt); end
    endtask

    // T6a: reset in the middle of a packet clears every output next edge.
    task automatic test_reset_mid_packet();
        eng_enable = 4'hF;
        tick();
        drive_beat(1'b1, 1'b0, 32'h70);
        tick();
        drive_beat(1'b0, 1'b0, 32'h77);
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        clear_beat();
        tests_run++; if (in_enable !== 1'b0 || eng_vld !== 4'h0 || eng_sop !== 4'h0 || eng_eop !== 4'h0) begin
            tests_failed++; $display("FAIL rst_mid in_enable/vld/sop/eop got=%0h/%0h/%0h/%0h exp=0", in_enable, eng_vld, eng_sop, eng_eop); end
        tests_run++; if (eng_data !== 32'h0 || grant_idx !== 2'd0 || pkt_cnt !== 8'd0 || err_pulse !== 1'b0) begin
            tests_failed++; $display("FAIL rst_mid data/grant/cnt/err got=%0h/%0d/%0d/%0h exp=0", eng_data, grant_idx, pkt_cnt, err_pulse); end
    endtask

    // T6b: packet counter reaches its maximum and wraps to zero.
    task automatic test_cnt_wrap();
        eng_enable = 4'hF;
        for (int p = 0; p < 255; p++) begin
            tick();
            drive_beat(1'b1, 1'b1, 32'(p));
            tick();
            clear_beat();
        end
        tests_run++; if (pkt_cnt !== 8'hFF) begin tests_failed++; $display("FAIL cnt_max got=%0h exp=ff", pkt_cnt); end
        tick();
        drive_beat(1'b1, 1'b1, 32'h1234);
        tick();
        clear_beat();
        tests_run++; if (pkt_cnt !== 8'h00) begin tests_failed++; $display("FAIL cnt_wrap got=%0h exp=0", pkt_cnt); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_multibeat();
        test_no_engine();
        test_withdraw();
        test_errors();
        test_reset_mid_packet();
        test_cnt_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
